downsampler_2x2: RTL
====================

Name: downsampler_2x2

Overview:
- Sits directly upstream of the upsampler's input FIFO.
- Consumes an 800x600 8-bit grayscale raster stream and produces a 400x300 stream. Each output pixel is the rounded mean of one non-overlapping 2x2 input block.
- Writes results straight into the external FIFO that the upsampler later drains.
- Uses one internal line buffer of horizontal pair sums. No frame buffer.

Parameters:
- IN_WIDTH, 800, active input pixels per row; must be even.
- IN_HEIGHT, 600, active input rows per frame; must be even.
- OUT_WIDTH, IN_WIDTH/2, derived; sets line buffer depth.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset.
- valid  input  1  data carries an active input pixel this cycle; may deassert at any time (gaps allowed).
- data  input  8  input pixel, raster order.
- fifo_full  input  1  downstream FIFO full flag.
- fifo_write  output  1  write strobe to the FIFO: validout AND NOT fifo_full.
- dataout  output  8  averaged output pixel.
- validout  output  1  dataout holds a new output pixel.
- overflow  output  1  sticky; set when validout is high while fifo_full is high.
- frame_done  output  1  one-cycle pulse when the last output pixel of a frame is produced.
- current_rowcount  output  10  input row of the next expected pixel.
- current_colcount  output  10  input column of the next expected pixel.

Behaviour:
- Reset (reset==0 at a clock edge):
  - col, row, pixel hold reg, output regs, overflow and frame_done all go to 0.
  - fifo_write and validout are 0.
  - Line buffer contents are not cleared. The next even row overwrites every entry before it is read.
- Counting:
  - Only cycles with valid==1 advance the counters.
  - col increments on each valid pixel. At IN_WIDTH-1 it wraps to 0 and row increments.
  - At row IN_HEIGHT-1, col IN_WIDTH-1, both counters wrap to 0.
  - Counters do not move on valid==0 cycles.
- Even column, valid:
  - Latch data into hold (8b).
  - Issue a line buffer read at address col>>1. The read is registered, so the data is available on the next valid cycle.
- Odd column, valid:
  - hsum = hold + data (9b, no overflow).
  - Even row: write hsum to linebuf[col>>1]. No output is produced.
  - Odd row: total = hsum + linebuf_rd + 2 (10b; max 1022).
    - The registered output stage loads dataout = total[9:2] and sets validout=1 on the next clock.
    - Latency: exactly 1 cycle after the 4th pixel of the block.
- Gap cycles between the even and odd column pixel must not corrupt hold or the read data. The read register holds its value until the next read.
- validout:
  - High for exactly one cycle per output pixel; otherwise 0.
  - dataout holds its last value when validout is 0.
  - Exactly OUT_WIDTH*IN_HEIGHT/2 = 120000 pulses per frame.
- Backpressure: there is no stall.
  - If fifo_full==1 while validout==1: fifo_write=0, the pixel is dropped and overflow is set.
  - overflow clears only on reset.
  - The input stream is never throttled.
- frame_done: pulses together with validout for the block at input row IN_HEIGHT-1, col IN_WIDTH-1.
- Reset mid-frame:
  - Counters restart at (0,0) on the next valid pixel.
  - Any partially accumulated block is discarded.
  - No validout is emitted for it.
- Line buffer:
  - OUT_WIDTH x 9b single-port array, synchronous read.
  - Read and write never target the same cycle: reads happen on even columns, writes on odd columns.

Test Plan:
- Constant frame, all pixels = 100, valid always high -> 120000 validout pulses, every dataout = 100; frame_done pulses once; counters return to (0,0).
- Block at (0,0) = 10, 20 / 30, 41 -> first output = (101+2)>>2 = 25, validout exactly 1 cycle after the row-1 col-1 pixel. Rounding checks:
  - block 1,1,1,2 -> 1
  - block 1,2,2,2 -> 2
  - all 255 -> 255, no wrap
- Random valid gaps (about 50% duty) with a ramp pattern data = (col+row)&255 -> output matches the golden 2x2 rounded mean. The output count and order are identical to the gap-free run.
- Hold fifo_full=1 for 10 cycles during row 1 -> fifo_write stays low during those cycles; overflow rises on the first collision and stays high after fifo_full drops; the remaining outputs still match the golden values.
- Assert reset at input row 3, col 157, then stream a full frame -> no validout from the partial block; the new frame yields 120000 correct outputs; overflow = 0 after reset.
- Two back-to-back frames with different constants (50, then 200) -> no cross-frame mixing; the first output of frame 2 = 200.

Source files
------------

// File: rtl/downsampler_2x2_if.sv
// Stream and FIFO-side signals of the 2x2 downsampler, grouped for port connection.
// The master drives pixels and the FIFO-full flag; the slave is the downsampler.
interface downsampler_2x2_if;
  logic       valid;
  logic [7:0] data;
  logic       fifo_full;
  logic       fifo_write;
  logic [7:0] dataout;
  logic       validout;
  logic       overflow;
  logic       frame_done;
  logic [9:0] current_rowcount;
  logic [9:0] current_colcount;

  modport master (
    output valid, data, fifo_full,
    input  fifo_write, dataout, validout, overflow, frame_done,
           current_rowcount, current_colcount
  );

  modport slave (
    input  valid, data, fifo_full,
    output fifo_write, dataout, validout, overflow, frame_done,
           current_rowcount, current_colcount
  );
endinterface

// File: rtl/downsampler_2x2.sv
// 2x2 block-averaging downsampler: each output pixel is the rounded mean of a
// non-overlapping 2x2 input block, using one line buffer of horizontal pair sums.
module downsampler_2x2 #(
  parameter int IN_WIDTH  = 800,
  parameter int IN_HEIGHT = 600,
  parameter int OUT_WIDTH = IN_WIDTH / 2
) (
  input  logic             clock,
  input  logic             reset,
  downsampler_2x2_if.slave bus
);

  localparam int AW = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;

  logic [9:0]    col;
  logic [9:0]    row;
  logic [7:0]    hold;
  logic [8:0]    rd_data;
  logic [8:0]    linebuf [OUT_WIDTH];
  logic [7:0]    dataout_q;
  logic          validout_q;
  logic          overflow_q;
  logic          frame_done_q;

  logic          even_col;
  logic          odd_row;
  logic          last_col;
  logic          last_row;
  logic [AW-1:0] addr;
  logic [8:0]    hsum;
  logic [7:0]    avg;

  assign even_col = ~col[0];
  assign odd_row  = row[0];
  assign last_col = (col == 10'(IN_WIDTH - 1));
  assign last_row = (row == 10'(IN_HEIGHT - 1));
  assign addr     = col[AW:1];
  assign hsum     = {1'b0, hold} + {1'b0, bus.data};
  // +2 before the divide by four rounds half up; the sum peaks at 1022.
  assign avg      = 8'(({1'b0, hsum} + {1'b0, rd_data} + 10'd2) >> 2);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      col          <= '0;
      row          <= '0;
      hold         <= '0;
      dataout_q    <= '0;
      validout_q   <= 1'b0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      validout_q   <= 1'b0;
      frame_done_q <= 1'b0;
      if (validout_q && bus.fifo_full) overflow_q <= 1'b1;

      if (bus.valid) begin
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + 10'd1;
        end else begin
          col <= col + 10'd1;
        end

        if (even_col) begin
          hold <= bus.data;
        end else if (odd_row) begin
          dataout_q    <= avg;
          validout_q   <= 1'b1;
          frame_done_q <= last_col && last_row;
        end
      end
    end
  end

  // NOTE: the line buffer and its read register carry no reset; each even row
  // rewrites every entry before the following odd row reads it.
  always_ff @(posedge clock) begin
    if (bus.valid) begin
      if (even_col)      rd_data       <= linebuf[addr];
      else if (!odd_row) linebuf[addr] <= hsum;
    end
  end

  assign bus.fifo_write       = validout_q & ~bus.fifo_full;
  assign bus.dataout          = dataout_q;
  assign bus.validout         = validout_q;
  assign bus.overflow         = overflow_q;
  assign bus.frame_done       = frame_done_q;
  assign bus.current_rowcount = row;
  assign bus.current_colcount = col;

endmodule
